// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : ID/EXE/MEM hazard-control bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_is_mdu;
  logic        id_mdu_div;
  logic        id_reads_hilo;
  logic        exe_rf_we;
  logic [4:0]  exe_rf_waddr;
  logic [1:0]  exe_rf_data_sel;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic        pc_we;
  logic        ii_we;
  logic        ie_we;
  logic        ie_bubble;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        mdu_start;
  logic        mdu_busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
    output id_is_mdu, id_mdu_div, id_reads_hilo,
    output exe_rf_we, exe_rf_waddr, exe_rf_data_sel,
    output mem_rf_we, mem_rf_waddr,
    input  pc_we, ii_we, ie_we, ie_bubble,
    input  fwd_rs_sel, fwd_rt_sel, mdu_start, mdu_busy, stall_cnt
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
    input  id_is_mdu, id_mdu_div, id_reads_hilo,
    input  exe_rf_we, exe_rf_waddr, exe_rf_data_sel,
    input  mem_rf_we, mem_rf_waddr,
    output pc_we, ii_we, ie_we, ie_bubble,
    output fwd_rs_sel, fwd_rt_sel, mdu_start, mdu_busy, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : load-use/MDU stall, operand forwarding, MDU sequencing.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mdu_hold;
  logic stall;
  logic mdu_busy;
  logic mdu_start;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exe_we,
    input logic [4:0] exe_waddr,
    input logic [1:0] exe_dsel,
    input logic       mem_we,
    input logic [4:0] mem_waddr
  );
    logic [1:0] sel;
    sel = 2'b00;
    // A load in EXE has no data yet; it is covered by the load-use stall instead.
    if (src != 5'd0 && exe_we && exe_waddr == src && exe_dsel != 2'b01)
      sel = 2'b01;
    else if (src != 5'd0 && mem_we && mem_waddr == src)
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    load_use = hz.exe_rf_we && (hz.exe_rf_data_sel == 2'b01) && (hz.exe_rf_waddr != 5'd0) &&
               ((hz.id_rs_used && hz.id_rs_addr == hz.exe_rf_waddr) ||
                (hz.id_rt_used && hz.id_rt_addr == hz.exe_rf_waddr));
    mdu_busy  = (state_q == ST_BUSY);
    mdu_hold  = mdu_busy && (hz.id_is_mdu || hz.id_reads_hilo);
    stall     = load_use || mdu_hold;
    mdu_start = (state_q == ST_IDLE) && hz.id_is_mdu && !stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu_start) begin
          state_d = ST_BUSY;
          cnt_d   = hz.id_mdu_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_we      = !stall;
  assign hz.ii_we      = !stall;
  assign hz.ie_we      = 1'b1;
  assign hz.ie_bubble  = stall;
  assign hz.fwd_rs_sel = fwd_sel(hz.id_rs_addr, hz.exe_rf_we, hz.exe_rf_waddr,
                                 hz.exe_rf_data_sel, hz.mem_rf_we, hz.mem_rf_waddr);
  assign hz.fwd_rt_sel = fwd_sel(hz.id_rt_addr, hz.exe_rf_we, hz.exe_rf_waddr,
                                 hz.exe_rf_data_sel, hz.mem_rf_we, hz.mem_rf_waddr);
  assign hz.mdu_start  = mdu_start;
  assign hz.mdu_busy   = mdu_busy;
  assign hz.stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : scenario tasks plus randomized run against a model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_rem    = 0;   // remaining busy cycles of the MDU
  int m_cnt    = 0;   // stall cycles seen, saturating

  function automatic logic [1:0] m_fwd(input logic [4:0] a);
    if (a != 0 && bus.exe_rf_we && bus.exe_rf_waddr == a && bus.exe_rf_data_sel != 2'b01) return 2'b01;
    if (a != 0 && bus.mem_rf_we && bus.mem_rf_waddr == a) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_load_use();
    if (!bus.exe_rf_we || bus.exe_rf_data_sel != 2'b01 || bus.exe_rf_waddr == 0) return 1'b0;
    return (bus.id_rs_used && bus.id_rs_addr == bus.exe_rf_waddr) ||
           (bus.id_rt_used && bus.id_rt_addr == bus.exe_rf_waddr);
  endfunction

  function automatic logic m_stall();
    return m_load_use() || (m_rem > 0 && (bus.id_is_mdu || bus.id_reads_hilo));
  endfunction

  function automatic logic m_start();
    return (m_rem == 0) && bus.id_is_mdu && !m_stall();
  endfunction

  task automatic tick();
    logic s;
    logic st;
    s  = m_stall();
    st = m_start();
    if (reset) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (st)             m_rem = bus.id_mdu_div ? DIV_N : MUL_N;
      else if (m_rem > 0) m_rem = m_rem - 1;
      if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_is_mdu = 0; bus.id_mdu_div = 0; bus.id_reads_hilo = 0;
    bus.exe_rf_we = 0; bus.exe_rf_waddr = 0; bus.exe_rf_data_sel = 0;
    bus.mem_rf_we = 0; bus.mem_rf_waddr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] act;
    do_reset();
    @(negedge clk);
    act = {bus.pc_we, bus.ii_we, bus.ie_we, bus.ie_bubble, bus.fwd_rs_sel, bus.fwd_rt_sel,
           bus.mdu_start, bus.mdu_busy, bus.stall_cnt};
    n_checks++;
    if (act !== {4'b1110, 4'b0000, 2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act, {4'b1110, 4'b0000, 2'b00, 16'h0000});
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.exe_rf_we = 1; bus.exe_rf_waddr = 5; bus.exe_rf_data_sel = 2'b01;
    bus.id_rs_addr = 5; bus.id_rs_used = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.pc_we, bus.ii_we, bus.ie_we, bus.ie_bubble} !== 4'b0011) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b expected 0011", {bus.pc_we, bus.ii_we, bus.ie_we, bus.ie_bubble});
    end
    n_checks++;
    if (bus.stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL load_use_cnt_before: got %0d expected 0", bus.stall_cnt);
    end
    tick();
    bus.exe_rf_we = 0; bus.exe_rf_waddr = 0; bus.exe_rf_data_sel = 0;
    bus.mem_rf_we = 1; bus.mem_rf_waddr = 5;
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_cnt_after: got %0d expected 1", bus.stall_cnt);
    end
    n_checks++;
    if ({bus.fwd_rs_sel, bus.pc_we, bus.ie_bubble} !== 4'b1010) begin
      n_fail++;
      $display("FAIL load_use_mem_fwd: got %b expected 1010", {bus.fwd_rs_sel, bus.pc_we, bus.ie_bubble});
    end
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    bus.exe_rf_we = 1; bus.exe_rf_waddr = 3; bus.mem_rf_we = 1; bus.mem_rf_waddr = 3;
    bus.id_rt_addr = 3; bus.id_rt_used = 1;
    @(negedge clk);
    n_checks++;
    if (bus.fwd_rt_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_exe_priority: got %b expected 01", bus.fwd_rt_sel);
    end
    bus.exe_rf_waddr = 0;
    @(negedge clk);
    n_checks++;
    if (bus.fwd_rt_sel !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_mem_path: got %b expected 10", bus.fwd_rt_sel);
    end
    bus.mem_rf_waddr = 0; bus.id_rt_addr = 0; bus.id_rs_addr = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.fwd_rs_sel, bus.fwd_rt_sel} !== 4'b0000) begin
      n_fail++;
      $display("FAIL fwd_reg0: got %b expected 0000", {bus.fwd_rs_sel, bus.fwd_rt_sel});
    end
    tick();
  endtask

  task automatic test_mult_mfhi();
    int base;
    clear_inputs();
    base = m_cnt;
    bus.id_is_mdu = 1; bus.id_mdu_div = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_start, bus.mdu_busy, bus.pc_we} !== 3'b101) begin
      n_fail++;
      $display("FAIL mult_launch: got %b expected 101", {bus.mdu_start, bus.mdu_busy, bus.pc_we});
    end
    tick();
    bus.id_is_mdu = 0; bus.id_reads_hilo = 1;
    for (int i = 1; i <= MUL_N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_start, bus.pc_we, bus.ie_bubble} !== 4'b1001) begin
        n_fail++;
        $display("FAIL mult_busy_cycle%0d: got %b expected 1001", i,
                 {bus.mdu_busy, bus.mdu_start, bus.pc_we, bus.ie_bubble});
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, bus.pc_we, bus.ie_bubble} !== 3'b010) begin
      n_fail++;
      $display("FAIL mfhi_issue: got %b expected 010", {bus.mdu_busy, bus.pc_we, bus.ie_bubble});
    end
    n_checks++;
    if (bus.stall_cnt !== 16'(base + MUL_N)) begin
      n_fail++;
      $display("FAIL mult_stall_cnt: got %0d expected %0d", bus.stall_cnt, base + MUL_N);
    end
    tick();
  endtask

  task automatic test_back_to_back_div();
    clear_inputs();
    bus.id_is_mdu = 1; bus.id_mdu_div = 1;
    @(negedge clk);
    n_checks++;
    if (bus.mdu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL div_launch: got %b expected 1", bus.mdu_start);
    end
    tick();
    for (int i = 1; i <= DIV_N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_start, bus.pc_we} !== 3'b100) begin
        n_fail++;
        $display("FAIL div_busy_cycle%0d: got %b expected 100", i, {bus.mdu_busy, bus.mdu_start, bus.pc_we});
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, bus.mdu_start, bus.pc_we} !== 3'b011) begin
      n_fail++;
      $display("FAIL div_second_launch: got %b expected 011", {bus.mdu_busy, bus.mdu_start, bus.pc_we});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    int k;
    clear_inputs();
    k = 0;
    while (bus.mdu_busy === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    n_checks++;
    if (bus.mdu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait_timeout: got busy=%b expected 0", bus.mdu_busy);
    end
    bus.id_is_mdu = 1; bus.id_mdu_div = 1;
    tick();
    bus.id_is_mdu = 0; bus.id_mdu_div = 0; bus.id_reads_hilo = 1;
    for (int i = 0; i < 9; i++) tick();
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, bus.pc_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_cycle10: got %b expected 10", {bus.mdu_busy, bus.pc_we});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, bus.pc_we, bus.ie_bubble, bus.stall_cnt} !== {3'b010, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got %b expected %b", {bus.mdu_busy, bus.pc_we, bus.ie_bubble, bus.stall_cnt},
               {3'b010, 16'h0000});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [25:0] act, exp;
    logic s;
    for (int i = 0; i < 400; i++) begin
      bus.id_rs_addr      = 5'($urandom_range(0, 3));
      bus.id_rt_addr      = 5'($urandom_range(0, 3));
      bus.id_rs_used      = 1'($urandom);
      bus.id_rt_used      = 1'($urandom);
      bus.id_is_mdu       = ($urandom_range(0, 3) == 0);
      bus.id_mdu_div      = ($urandom_range(0, 3) == 0);
      bus.id_reads_hilo   = ($urandom_range(0, 3) == 0);
      bus.exe_rf_we       = 1'($urandom);
      bus.exe_rf_waddr    = 5'($urandom_range(0, 3));
      bus.exe_rf_data_sel = 2'($urandom);
      bus.mem_rf_we       = 1'($urandom);
      bus.mem_rf_waddr    = 5'($urandom_range(0, 3));
      reset               = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      s   = m_stall();
      exp = {!s, !s, 1'b1, s, m_fwd(bus.id_rs_addr), m_fwd(bus.id_rt_addr),
             m_start(), (m_rem > 0), 16'(m_cnt)};
      act = {bus.pc_we, bus.ii_we, bus.ie_we, bus.ie_bubble, bus.fwd_rs_sel, bus.fwd_rt_sel,
             bus.mdu_start, bus.mdu_busy, bus.stall_cnt};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, act, exp);
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.exe_rf_we = 1; bus.exe_rf_waddr = 7; bus.exe_rf_data_sel = 2'b01;
    bus.id_rt_addr = 7; bus.id_rt_used = 1;
    for (int i = 0; i < 65534; i++) tick();
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre: got %h expected fffe", bus.stall_cnt);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %h expected ffff", bus.stall_cnt);
    end
    for (int i = 0; i < 70000 - 65535; i++) tick();
    @(negedge clk);
    n_checks++;
    if ({bus.stall_cnt, bus.pc_we} !== {16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_hold: got %h/%b expected ffff/0", bus.stall_cnt, bus.pc_we);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forward();
    test_mult_mfhi();
    test_back_to_back_div();
    test_reset_mid_busy();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage static pipeline. It works in the opposite direction to the stage registers: it observes ID-stage source operands and the EXE/MEM destination fields coming back down the pipe. From these it drives the write-enables and bubble control of the PC, IF/ID and ID/EXE registers, the operand-forwarding selects, and the issue/busy sequencing of the multi-cycle multiply/divide unit (MDU). It also keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- MUL_CYCLES, default 4: multiply occupancy in cycles (≥1).
- DIV_CYCLES, default 32: divide occupancy in cycles (≥1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs_addr / id_rt_addr  in  5  source register numbers of the instruction in ID.
- id_rs_used / id_rt_used  in  1  source is actually read.
- id_is_mdu  in  1  ID instruction is mult/multu/div/divu.
- id_mdu_div  in  1  qualifies id_is_mdu: 1 = divide, 0 = multiply.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- exe_rf_we, exe_rf_waddr[4:0], exe_rf_data_sel[1:0]  in  EXE-stage destination info; data_sel 2'b01 = load result.
- mem_rf_we, mem_rf_waddr[4:0]  in  MEM-stage destination info.
- pc_we  out  1  PC update enable.
- ii_we  out  1  IF/ID register write enable.
- ie_we  out  1  ID/EXE register write enable.
- ie_bubble  out  1  top level forces zero rf_we/dmem_we into ID/EXE.
- fwd_rs_sel / fwd_rt_sel  out  2  00 regfile, 01 EXE ALU result, 10 MEM result, 11 unused.
- mdu_start  out  1  one-cycle MDU launch.
- mdu_busy  out  1  MDU occupied.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- load_use = exe_rf_we & exe_rf_data_sel==2'b01 & exe_rf_waddr!=0 & ((id_rs_used & id_rs_addr==exe_rf_waddr) | (id_rt_used & id_rt_addr==exe_rf_waddr)).
- mdu_hold = mdu_busy & (id_is_mdu | id_reads_hilo).
- stall = load_use | mdu_hold.
- Stall response: pc_we=0, ii_we=0, ie_we=1, ie_bubble=1.
- No-stall response: pc_we=ii_we=ie_we=1, ie_bubble=0.
- Forwarding, per source, is combinational:
  - Select 01 when exe_rf_we, the address matches, the address is nonzero and exe_rf_data_sel!=01.
  - Otherwise select 10 on a MEM match (mem_rf_we, nonzero address).
  - Otherwise select 00.
  - EXE has priority over MEM.
  - Register 0 is never forwarded.
- MDU FSM states IDLE, BUSY. Counter width is clog2(max(MUL_CYCLES,DIV_CYCLES)).
  - IDLE: if id_is_mdu & !stall, assert mdu_start this cycle, load the counter with (id_mdu_div ? DIV_CYCLES : MUL_CYCLES)−1, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: mdu_busy=1. Counter decrements each cycle. When the counter reaches 0, go to IDLE on the next edge.
  - mdu_start is never asserted in BUSY or during any stall.
- stall_cnt increments each cycle stall=1 and saturates at 16'hFFFF.

## Timing
- All control outputs are combinational from inputs and state, with no added latency. Stage registers sample them at the same edge.
- Reset values, with all inputs at 0: state IDLE, counter 0, stall_cnt 0, mdu_busy 0, mdu_start 0, pc_we=ii_we=ie_we=1, ie_bubble 0, fwd selects 00.
- Load-use costs exactly 1 stall cycle: the next cycle the load is in MEM, so the MEM forward path is used.
- MDU launched in cycle T: mdu_busy=1 in T+1 … T+N, where N = MUL_CYCLES or DIV_CYCLES. IDLE in T+N+1.
- A dependent mfhi sitting in ID during T+1 stalls N cycles and issues in T+N+1.
- Simultaneous load_use and mdu_hold: a single stall, counted once in stall_cnt.
- MDU instruction in ID while load_use: no start; the launch occurs on the first non-stalled cycle.
- Reset mid-BUSY: the next edge forces IDLE, counter 0, stall_cnt 0. A pending stall is released in the same cycle outputs are reevaluated.

## Test plan
- Load to $5 in EXE (data_sel 01), ID reads rs=$5:
  - stall cycle: pc_we=0, ii_we=0, ie_bubble=1, stall_cnt 0→1.
  - next cycle (load in MEM): fwd_rs_sel=10, no stall.
- ALU writes $3 in EXE and a different ALU op writes $3 in MEM, ID reads rt=$3 → fwd_rt_sel=01. With exe_rf_waddr=0 → fwd_rt_sel=10 only on a nonzero MEM match. Register $0 → 00 always.
- mult in ID at T, MUL_CYCLES=4 → mdu_start=1 at T; mdu_busy=1 for T+1..T+4; mfhi in ID stalls T+1..T+4 and issues at T+5; stall_cnt=4.
- div with DIV_CYCLES=32 → busy exactly 32 cycles. A second div in ID during busy → no mdu_start until the first cycle after busy drops.
- reset asserted at busy cycle 10 of a div → next cycle mdu_busy=0, pc_we=1, stall_cnt=0.
- Force stall for 70000 cycles → stall_cnt holds 16'hFFFF without wrapping.
